// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared types and constants for the RV32 pipeline register scoreboard.
//   reg_idx_t  : architectural register index
//   lat_t      : bounded-latency field (issue-to-forwardable cycles)
//   sb_entry_t : per-register scoreboard state {cnt, long}
//   LAT_ALU / LAT_LOAD : latencies of the single-cycle ALU and the load path
package pipeline_pkg;

  localparam int SB_NUM_REGS = 32;
  localparam int SB_REG_W    = $clog2(SB_NUM_REGS);
  localparam int SB_LAT_W    = 3;

  typedef logic [SB_REG_W-1:0] reg_idx_t;
  typedef logic [SB_LAT_W-1:0] lat_t;

  localparam lat_t LAT_ALU  = 3'd1;
  localparam lat_t LAT_LOAD = 3'd2;

  typedef struct packed {
    lat_t cnt;
    logic long;
  } sb_entry_t;

  // Countdown value loaded at issue: a latency of L leaves L-1 stall cycles,
  // and a latency of 0 behaves like 1.
  function automatic lat_t lat_to_cnt(input lat_t lat);
    lat_t res;
    if (lat == 3'd0) begin
      res = 3'd0;
    end else begin
      res = lat - 3'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// sb_entry
// State for one architectural register: a bounded-latency countdown and a
// long-latency pending flag.
// Priority on each rising clk edge: issue update > (decrement, wb clear).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   set_en      : an instruction writing this register fires this cycle
//   set_long    : that instruction is variable latency
//   set_cnt     : countdown to load for a bounded-latency instruction
//   wb_clr      : long-latency unit writes this register back this cycle
//   cnt, long   : current state (registered)
module sb_entry
  import pipeline_pkg::*;
#(
  parameter int LAT_W = SB_LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic             set_long,
  input  logic [LAT_W-1:0] set_cnt,
  input  logic             wb_clr,
  output logic [LAT_W-1:0] cnt,
  output logic             long
);

  logic [LAT_W-1:0] cnt_r;
  logic             long_r;

  // Countdown / long-flag update with issue overriding decrement and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      long_r <= 1'b0;
    end else if (set_en) begin
      if (set_long) begin
        cnt_r  <= '0;
        long_r <= 1'b1;
      end else begin
        cnt_r  <= set_cnt;
        long_r <= 1'b0;
      end
    end else begin
      if (cnt_r != '0) begin
        cnt_r <= cnt_r - LAT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (wb_clr) begin
        long_r <= 1'b0;
      end else begin
        long_r <= long_r;
      end
    end
  end

  assign cnt  = cnt_r;
  assign long = long_r;

endmodule

// File: rtl/pipeline_scoreboard.sv
// pipeline_scoreboard
// Register scoreboard for the RV32 ID stage. Tracks pending destination
// registers (bounded countdown or long-latency flag) and produces the ID
// stall and the issue-fire strobe combinationally from the current issue
// and the registered scoreboard state.
// Ports:
//   clk, resetn                     : clock, asynchronous active-low reset
//   issue_valid                     : ID holds a valid instruction
//   issue_rs1/rs2, issue_use_rs1/2  : source indices and read enables
//   issue_rd, issue_wr              : destination index and write enable
//   issue_lat                       : bounded latency (0 treated as 1)
//   issue_long                      : variable-latency instruction
//   flush                           : squashes this cycle's issue
//   wb_valid, wb_rd                 : long-latency writeback
//   stall                           : hold PC/IF-ID, bubble into ID/EX
//   issue_fire                      : instruction enters EX this cycle
//   busy_vec                        : per-register pending bits
// Optional: define SCOREBOARD_STATS_EN to add the saturating counters
//   stall_cycles (cycles with stall) and raw_stalls (stalls caused by a
//   source hazard).
module pipeline_scoreboard
  import pipeline_pkg::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int REG_W    = $clog2(NUM_REGS),
  parameter int LAT_W    = SB_LAT_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                issue_valid,
  input  logic [REG_W-1:0]    issue_rs1,
  input  logic [REG_W-1:0]    issue_rs2,
  input  logic                issue_use_rs1,
  input  logic                issue_use_rs2,
  input  logic [REG_W-1:0]    issue_rd,
  input  logic                issue_wr,
  input  logic [LAT_W-1:0]    issue_lat,
  input  logic                issue_long,
  input  logic                flush,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
`ifdef SCOREBOARD_STATS_EN
  output logic [31:0]         stall_cycles,
  output logic [31:0]         raw_stalls,
`endif
  output logic                stall,
  output logic                issue_fire,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [LAT_W-1:0]    cnt_s [NUM_REGS];
  logic [NUM_REGS-1:0] long_s;
  logic [NUM_REGS-1:0] busy_s;
  logic [NUM_REGS-1:0] wb_clr_s;

  logic             rs1_haz_s;
  logic             rs2_haz_s;
  logic             waw_haz_s;
  logic             src_haz_s;
  logic             stall_s;
  logic             fire_s;
  logic             rd_upd_s;
  logic [LAT_W-1:0] set_cnt_s;

  // Register 0 is hardwired zero and never pending.
  assign cnt_s[0]    = '0;
  assign long_s[0]   = 1'b0;
  assign wb_clr_s[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_entry
      logic set_en_s;
      assign set_en_s    = rd_upd_s & (issue_rd == REG_W'(r));
      assign wb_clr_s[r] = wb_valid & (wb_rd == REG_W'(r));

      sb_entry #(
        .LAT_W (LAT_W)
      ) u_entry (
        .clk      (clk),
        .rst_n    (resetn),
        .set_en   (set_en_s),
        .set_long (issue_long),
        .set_cnt  (set_cnt_s),
        .wb_clr   (wb_clr_s[r]),
        .cnt      (cnt_s[r]),
        .long     (long_s[r])
      );
    end
  endgenerate

  // Busy vector from registered per-register state.
  always_comb begin
    busy_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_s[i] = (cnt_s[i] != '0) | long_s[i];
    end
  end

  // Hazard detection, stall and fire; a same-cycle long writeback to a
  // register is picked up by WB forwarding, so it does not hold the issue.
  always_comb begin
    rs1_haz_s = issue_use_rs1 & (issue_rs1 != '0) & busy_s[issue_rs1]
              & ~(wb_valid & (wb_rd == issue_rs1));
    rs2_haz_s = issue_use_rs2 & (issue_rs2 != '0) & busy_s[issue_rs2]
              & ~(wb_valid & (wb_rd == issue_rs2));
    waw_haz_s = issue_wr & (issue_rd != '0) & long_s[issue_rd]
              & ~(wb_valid & (wb_rd == issue_rd));
    src_haz_s = rs1_haz_s | rs2_haz_s;
    stall_s   = issue_valid & ~flush & (src_haz_s | waw_haz_s);
    fire_s    = issue_valid & ~flush & ~stall_s;
    rd_upd_s  = fire_s & issue_wr & (issue_rd != '0);
  end

  // Countdown loaded at issue: latency L forwards after L-1 stall cycles.
  always_comb begin
    if (issue_lat == '0) begin
      set_cnt_s = '0;
    end else begin
      set_cnt_s = issue_lat - LAT_W'(1);
    end
  end

  assign stall      = stall_s;
  assign issue_fire = fire_s;
  assign busy_vec   = busy_s;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_r;
  logic [31:0] raw_stalls_r;

  // Saturating stall statistics.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles_r <= 32'd0;
      raw_stalls_r   <= 32'd0;
    end else begin
      if (stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (stall_s && src_haz_s && (raw_stalls_r != 32'hFFFF_FFFF)) begin
        raw_stalls_r <= raw_stalls_r + 32'd1;
      end else begin
        raw_stalls_r <= raw_stalls_r;
      end
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign raw_stalls   = raw_stalls_r;
`endif

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb_pipeline_scoreboard
// Directed stimulus; each cycle's expected stall / issue_fire / masked
// busy_vec is queued by the stimulus and popped by a separate monitor on
// the falling clock edge.
module tb_pipeline_scoreboard;
  import pipeline_pkg::*;

  localparam int N  = 32;
  localparam int RW = 5;
  localparam int LW = 3;

  logic          clk;
  logic          resetn;
  logic          issue_valid;
  logic [RW-1:0] issue_rs1;
  logic [RW-1:0] issue_rs2;
  logic          issue_use_rs1;
  logic          issue_use_rs2;
  logic [RW-1:0] issue_rd;
  logic          issue_wr;
  logic [LW-1:0] issue_lat;
  logic          issue_long;
  logic          flush;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic          stall;
  logic          issue_fire;
  logic [N-1:0]  busy_vec;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   raw_stalls;
`endif

  pipeline_scoreboard dut (
    .clk           (clk),
    .resetn        (resetn),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_rd      (issue_rd),
    .issue_wr      (issue_wr),
    .issue_lat     (issue_lat),
    .issue_long    (issue_long),
    .flush         (flush),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
`ifdef SCOREBOARD_STATS_EN
    .stall_cycles  (stall_cycles),
    .raw_stalls    (raw_stalls),
`endif
    .stall         (stall),
    .issue_fire    (issue_fire),
    .busy_vec      (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         stall;
    logic         fire;
    logic [N-1:0] mask;
    logic [N-1:0] val;
    int           tag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   tag_cnt = 0;

  localparam logic [N-1:0] ALL = {N{1'b1}};

  // Monitor: compare the DUT against the queued expectation each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (stall !== e.stall) begin
        errors++;
        $display("FAIL stall step=%0d got=%0b exp=%0b", e.tag, stall, e.stall);
      end
      checks++;
      if (issue_fire !== e.fire) begin
        errors++;
        $display("FAIL issue_fire step=%0d got=%0b exp=%0b", e.tag, issue_fire, e.fire);
      end
      if (e.mask != '0) begin
        checks++;
        if ((busy_vec & e.mask) !== (e.val & e.mask)) begin
          errors++;
          $display("FAIL busy_vec step=%0d got=%h exp=%h mask=%h",
                   e.tag, busy_vec & e.mask, e.val & e.mask, e.mask);
        end
      end
    end
  end

  function automatic logic [N-1:0] b(input int i);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  task automatic idle();
    issue_valid   = 1'b0;
    issue_rs1     = 5'd0;
    issue_rs2     = 5'd0;
    issue_use_rs1 = 1'b0;
    issue_use_rs2 = 1'b0;
    issue_rd      = 5'd0;
    issue_wr      = 1'b0;
    issue_lat     = 3'd0;
    issue_long    = 1'b0;
    flush         = 1'b0;
    wb_valid      = 1'b0;
    wb_rd         = 5'd0;
  endtask

  task automatic set_issue(input int rs1, input logic u1, input int rs2, input logic u2,
                           input int rd, input logic wr, input logic [LW-1:0] lat,
                           input logic lng);
    issue_valid   = 1'b1;
    issue_rs1     = RW'(rs1);
    issue_use_rs1 = u1;
    issue_rs2     = RW'(rs2);
    issue_use_rs2 = u2;
    issue_rd      = RW'(rd);
    issue_wr      = wr;
    issue_lat     = lat;
    issue_long    = lng;
    flush         = 1'b0;
    wb_valid      = 1'b0;
    wb_rd         = 5'd0;
  endtask

  // Queue the expectation for the current cycle, then advance one cycle.
  task automatic tick(input logic s, input logic f, input logic [N-1:0] m,
                      input logic [N-1:0] v);
    exp_t e;
    tag_cnt++;
    e.stall = s;
    e.fire  = f;
    e.mask  = m;
    e.val   = v;
    e.tag   = tag_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    @(posedge clk);
    #1;

    // In reset: nothing busy, a valid issue fires.
    set_issue(1, 1'b1, 2, 1'b1, 3, 1'b1, LAT_ALU, 1'b0);
    tick(1'b0, 1'b1, ALL, '0);
    resetn = 1'b1;
    idle();
    tick(1'b0, 1'b0, ALL, '0);

    // Load x5 then dependent add x6,x5,x1: one bubble.
    set_issue(0, 1'b0, 0, 1'b0, 5, 1'b1, LAT_LOAD, 1'b0);
    tick(1'b0, 1'b1, b(5), '0);
    set_issue(5, 1'b1, 1, 1'b1, 6, 1'b1, LAT_ALU, 1'b0);
    tick(1'b1, 1'b0, b(5), b(5));
    tick(1'b0, 1'b1, b(5), '0);
    idle();
    tick(1'b0, 1'b0, b(5) | b(6), '0);

    // ALU x7 then dependent: no bubble, x7 never busy.
    set_issue(0, 1'b0, 0, 1'b0, 7, 1'b1, LAT_ALU, 1'b0);
    tick(1'b0, 1'b1, b(7), '0);
    set_issue(7, 1'b1, 7, 1'b1, 8, 1'b1, LAT_ALU, 1'b0);
    tick(1'b0, 1'b1, b(7), '0);
    idle();
    tick(1'b0, 1'b0, b(7) | b(8), '0);

    // Divider x9: dependent stalls 9 cycles, fires with the writeback.
    set_issue(1, 1'b1, 2, 1'b1, 9, 1'b1, LAT_ALU, 1'b1);
    tick(1'b0, 1'b1, b(9), '0);
    set_issue(2, 1'b1, 9, 1'b1, 10, 1'b1, LAT_ALU, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      tick(1'b1, 1'b0, b(9) | b(10), b(9));
    end
    wb_valid = 1'b1;
    wb_rd    = 5'd9;
    tick(1'b0, 1'b1, b(9), b(9));
    idle();
    tick(1'b0, 1'b0, b(9) | b(10), '0);

    // WAW on long-pending x3; writeback to another register does not help.
    set_issue(0, 1'b0, 0, 1'b0, 3, 1'b1, LAT_ALU, 1'b1);
    tick(1'b0, 1'b1, b(3), '0);
    set_issue(0, 1'b0, 0, 1'b0, 3, 1'b1, LAT_ALU, 1'b0);
    tick(1'b1, 1'b0, b(3), b(3));
    wb_valid = 1'b1;
    wb_rd    = 5'd4;
    tick(1'b1, 1'b0, b(3), b(3));
    wb_rd    = 5'd3;
    tick(1'b0, 1'b1, b(3), b(3));
    idle();
    tick(1'b0, 1'b0, b(3), '0);

    // Latency 0 acts as 1; latency 3 gives two bubbles; latency 7 keeps
    // the register busy for six cycles.
    set_issue(0, 1'b0, 0, 1'b0, 11, 1'b1, 3'd0, 1'b0);
    tick(1'b0, 1'b1, b(11), '0);
    set_issue(11, 1'b1, 0, 1'b0, 12, 1'b1, 3'd3, 1'b0);
    tick(1'b0, 1'b1, b(11), '0);
    set_issue(0, 1'b0, 12, 1'b1, 13, 1'b1, 3'd7, 1'b0);
    tick(1'b1, 1'b0, b(12), b(12));
    tick(1'b1, 1'b0, b(12), b(12));
    tick(1'b0, 1'b1, b(12), '0);
    idle();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, b(13), b(13));
    end
    tick(1'b0, 1'b0, b(13), '0);

    // Flush squashes the issue but the countdown keeps running.
    set_issue(0, 1'b0, 0, 1'b0, 5, 1'b1, 3'd3, 1'b0);
    tick(1'b0, 1'b1, b(5), '0);
    set_issue(5, 1'b1, 0, 1'b0, 6, 1'b1, LAT_ALU, 1'b0);
    flush = 1'b1;
    tick(1'b0, 1'b0, b(5), b(5));
    flush = 1'b0;
    tick(1'b1, 1'b0, b(5), b(5));
    tick(1'b0, 1'b1, b(5), '0);

    // Long x4 pending, asynchronous reset mid-cycle clears it.
    set_issue(0, 1'b0, 0, 1'b0, 4, 1'b1, LAT_ALU, 1'b1);
    tick(1'b0, 1'b1, b(4), '0);
    idle();
    tick(1'b0, 1'b0, b(4), b(4));
    set_issue(4, 1'b1, 0, 1'b0, 14, 1'b1, LAT_ALU, 1'b0);
    #2;
    resetn = 1'b0;
    tick(1'b0, 1'b1, ALL, '0);
    resetn = 1'b1;
    tick(1'b0, 1'b1, b(4), '0);

    // Writes to x0 never mark it busy, reads of x0 never stall.
    set_issue(0, 1'b0, 0, 1'b0, 0, 1'b1, LAT_ALU, 1'b1);
    tick(1'b0, 1'b1, b(0), '0);
    set_issue(0, 1'b1, 0, 1'b1, 0, 1'b1, LAT_LOAD, 1'b0);
    tick(1'b0, 1'b1, ALL, '0);
    idle();
    tick(1'b0, 1'b0, ALL, '0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
